// File: rtl/dual_wb_regfile.sv
// dual_wb_regfile
//   Writeback stage for the dual-issue pipeline. Holds one two-line bundle
//   from MEM, commits both lines' GPR and LLbit writes, and serves the four
//   ID read ports plus the LLbit read with same-cycle WB bypass.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   mem_valid_i / wb_allowin_o MEM->WB handshake
//   wb_stall_i, flush_i        hold the WB bundle / drop the incoming bundle
//   lk_*_i (k = 1,2)           per-line payload: valid, GPR write, LLbit write
//   re_i, raddr_i, rdata_o     4 read ports packed {l2_re2, l2_re1, l1_re2, l1_re1}
//   llbit_rdata_o              LLbit with bypass
//   wb_valid_o, commit_o       WB occupancy, per-line commit strobe {l2, l1}
module dual_wb_regfile #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid_i,
  output logic            wb_allowin_o,
  input  logic            wb_stall_i,
  input  logic            flush_i,
  input  logic            l1_valid_i,
  input  logic            l2_valid_i,
  input  logic            l1_we_i,
  input  logic            l2_we_i,
  input  logic [AW-1:0]   l1_waddr_i,
  input  logic [AW-1:0]   l2_waddr_i,
  input  logic [DW-1:0]   l1_wdata_i,
  input  logic [DW-1:0]   l2_wdata_i,
  input  logic            l1_llbit_we_i,
  input  logic            l1_llbit_wdata_i,
  input  logic            l2_llbit_we_i,
  input  logic            l2_llbit_wdata_i,
  input  logic [3:0]      re_i,
  input  logic [4*AW-1:0] raddr_i,
  output logic [4*DW-1:0] rdata_o,
  output logic            llbit_rdata_o,
  output logic            wb_valid_o,
  output logic [1:0]      commit_o
);

  logic            wb_valid_q;
  logic            l1_valid_q, l2_valid_q;
  logic            l1_we_q, l2_we_q;
  logic [AW-1:0]   l1_waddr_q, l2_waddr_q;
  logic [DW-1:0]   l1_wdata_q, l2_wdata_q;
  logic            l1_llbit_we_q, l1_llbit_wdata_q;
  logic            l2_llbit_we_q, l2_llbit_wdata_q;
  logic [DW-1:0]   gpr_q [NREG];
  logic            llbit_q;

  logic            ready_go;
  logic            l1_commit, l2_commit;
  logic            l1_gpr_wr, l2_gpr_wr;
  logic            l1_ll_wr, l2_ll_wr;

  assign ready_go     = !wb_stall_i;
  assign wb_allowin_o = !wb_valid_q || ready_go;
  assign wb_valid_o   = wb_valid_q;

  assign l1_commit = wb_valid_q && ready_go && l1_valid_q;
  assign l2_commit = wb_valid_q && ready_go && l2_valid_q;
  assign commit_o  = {l2_commit, l1_commit};

  // r0 is never written, so it stays at its reset value of zero.
  assign l1_gpr_wr = l1_commit && l1_we_q && (l1_waddr_q != '0);
  assign l2_gpr_wr = l2_commit && l2_we_q && (l2_waddr_q != '0);
  assign l1_ll_wr  = l1_commit && l1_llbit_we_q;
  assign l2_ll_wr  = l2_commit && l2_llbit_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q       <= 1'b0;
      l1_valid_q       <= 1'b0;
      l2_valid_q       <= 1'b0;
      l1_we_q          <= 1'b0;
      l2_we_q          <= 1'b0;
      l1_waddr_q       <= '0;
      l2_waddr_q       <= '0;
      l1_wdata_q       <= '0;
      l2_wdata_q       <= '0;
      l1_llbit_we_q    <= 1'b0;
      l1_llbit_wdata_q <= 1'b0;
      l2_llbit_we_q    <= 1'b0;
      l2_llbit_wdata_q <= 1'b0;
    end else if (wb_allowin_o) begin
      wb_valid_q <= mem_valid_i && !flush_i;
      if (mem_valid_i) begin
        l1_valid_q       <= l1_valid_i;
        l2_valid_q       <= l2_valid_i;
        l1_we_q          <= l1_we_i;
        l2_we_q          <= l2_we_i;
        l1_waddr_q       <= l1_waddr_i;
        l2_waddr_q       <= l2_waddr_i;
        l1_wdata_q       <= l1_wdata_i;
        l2_wdata_q       <= l2_wdata_i;
        l1_llbit_we_q    <= l1_llbit_we_i;
        l1_llbit_wdata_q <= l1_llbit_wdata_i;
        l2_llbit_we_q    <= l2_llbit_we_i;
        l2_llbit_wdata_q <= l2_llbit_wdata_i;
      end
    end
  end

  // Line2 is younger: its write is issued last so it wins on an address clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      llbit_q <= 1'b0;
    end else begin
      if (l1_gpr_wr) gpr_q[l1_waddr_q] <= l1_wdata_q;
      if (l2_gpr_wr) gpr_q[l2_waddr_q] <= l2_wdata_q;
      if (l2_ll_wr)      llbit_q <= l2_llbit_wdata_q;
      else if (l1_ll_wr) llbit_q <= l1_llbit_wdata_q;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < 4; p++) begin
      if (re_i[p] && (raddr_i[p*AW +: AW] != '0)) begin
        if (l2_gpr_wr && (l2_waddr_q == raddr_i[p*AW +: AW]))
          rdata_o[p*DW +: DW] = l2_wdata_q;
        else if (l1_gpr_wr && (l1_waddr_q == raddr_i[p*AW +: AW]))
          rdata_o[p*DW +: DW] = l1_wdata_q;
        else
          rdata_o[p*DW +: DW] = gpr_q[raddr_i[p*AW +: AW]];
      end
    end
  end

  always_comb begin
    if (l2_ll_wr)      llbit_rdata_o = l2_llbit_wdata_q;
    else if (l1_ll_wr) llbit_rdata_o = l1_llbit_wdata_q;
    else               llbit_rdata_o = llbit_q;
  end

endmodule

// File: tb/tb_dual_wb_regfile.sv
module tb_dual_wb_regfile;

  typedef struct packed {
    logic        v1;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        llwe1;
    logic        lld1;
    logic        v2;
    logic        we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic        llwe2;
    logic        lld2;
  } bundle_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_valid_i, wb_stall_i, flush_i;
  bundle_t      in_b;
  logic [3:0]   re_i;
  logic [19:0]  raddr_i;
  logic [127:0] rdata_o;
  logic         wb_allowin_o, llbit_rdata_o, wb_valid_o;
  logic [1:0]   commit_o;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state plus the bundle sitting in WB.
  logic [31:0] m_regs [32];
  logic        m_ll;
  logic        m_wbv;
  bundle_t     m_b;

  always #5 clk = ~clk;

  dual_wb_regfile #(.NREG(32), .AW(5), .DW(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_valid_i      (mem_valid_i),
    .wb_allowin_o     (wb_allowin_o),
    .wb_stall_i       (wb_stall_i),
    .flush_i          (flush_i),
    .l1_valid_i       (in_b.v1),
    .l2_valid_i       (in_b.v2),
    .l1_we_i          (in_b.we1),
    .l2_we_i          (in_b.we2),
    .l1_waddr_i       (in_b.wa1),
    .l2_waddr_i       (in_b.wa2),
    .l1_wdata_i       (in_b.wd1),
    .l2_wdata_i       (in_b.wd2),
    .l1_llbit_we_i    (in_b.llwe1),
    .l1_llbit_wdata_i (in_b.lld1),
    .l2_llbit_we_i    (in_b.llwe2),
    .l2_llbit_wdata_i (in_b.lld2),
    .re_i             (re_i),
    .raddr_i          (raddr_i),
    .rdata_o          (rdata_o),
    .llbit_rdata_o    (llbit_rdata_o),
    .wb_valid_o       (wb_valid_o),
    .commit_o         (commit_o)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ll  = 1'b0;
    m_wbv = 1'b0;
    m_b   = '0;
  endtask

  function automatic logic m_go();
    return m_wbv && !wb_stall_i;
  endfunction

  function automatic logic [31:0] exp_read(logic re, logic [4:0] a);
    if (!re || a == 5'd0) return 32'h0;
    if (m_go() && m_b.v2 && m_b.we2 && m_b.wa2 == a) return m_b.wd2;
    if (m_go() && m_b.v1 && m_b.we1 && m_b.wa1 == a) return m_b.wd1;
    return m_regs[a];
  endfunction

  function automatic logic exp_ll();
    if (m_go() && m_b.v2 && m_b.llwe2) return m_b.lld2;
    if (m_go() && m_b.v1 && m_b.llwe1) return m_b.lld1;
    return m_ll;
  endfunction

  function automatic logic [1:0] exp_commit();
    return m_go() ? {m_b.v2, m_b.v1} : 2'b00;
  endfunction

  // One clock: advance the model with the inputs present at the edge,
  // and return at the following falling edge.
  task automatic tick();
    logic allow;
    @(posedge clk);
    allow = !m_wbv || !wb_stall_i;
    if (m_go()) begin
      if (m_b.v1 && m_b.we1 && m_b.wa1 != 0) m_regs[m_b.wa1] = m_b.wd1;
      if (m_b.v1 && m_b.llwe1) m_ll = m_b.lld1;
      if (m_b.v2 && m_b.we2 && m_b.wa2 != 0) m_regs[m_b.wa2] = m_b.wd2;
      if (m_b.v2 && m_b.llwe2) m_ll = m_b.lld2;
    end
    if (allow) begin
      m_wbv = mem_valid_i && !flush_i;
      if (mem_valid_i) m_b = in_b;
    end
    @(negedge clk);
  endtask

  task automatic set_reads(input logic [4:0] a0, a1, a2, a3);
    re_i    = 4'hF;
    raddr_i = {a3, a2, a1, a0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_valid_i = 0; wb_stall_i = 0; flush_i = 0; in_b = '0;
    set_reads(5'd5, 5'd0, 5'd5, 5'd0);
    model_reset();
    #12;
    checks++; if (wb_allowin_o !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b want 1", wb_allowin_o); end
    checks++; if (commit_o !== 2'b00) begin errors++; $display("FAIL reset_commit got %b want 00", commit_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid_o); end
    checks++; if (llbit_rdata_o !== 1'b0) begin errors++; $display("FAIL reset_llbit got %b want 0", llbit_rdata_o); end
    checks++; if (rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h want 0", rdata_o[31:0]); end
    checks++; if (rdata_o[63:32] !== 32'h0) begin errors++; $display("FAIL reset_r0 got %h want 0", rdata_o[63:32]); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dual_write();
    in_b = '0;
    in_b.v1 = 1; in_b.we1 = 1; in_b.wa1 = 5'd3; in_b.wd1 = 32'h11111111;
    in_b.v2 = 1; in_b.we2 = 1; in_b.wa2 = 5'd4; in_b.wd2 = 32'h22222222;
    mem_valid_i = 1;
    tick();
    mem_valid_i = 0; in_b = '0;
    set_reads(5'd3, 5'd4, 5'd3, 5'd4);
    #1;
    checks++; if (commit_o !== 2'b11) begin errors++; $display("FAIL dual_commit got %b want 11", commit_o); end
    checks++; if (rdata_o[31:0] !== 32'h11111111) begin errors++; $display("FAIL dual_bypass_r3 got %h want 11111111", rdata_o[31:0]); end
    checks++; if (rdata_o[63:32] !== 32'h22222222) begin errors++; $display("FAIL dual_bypass_r4 got %h want 22222222", rdata_o[63:32]); end
    tick(); #1;
    checks++; if (commit_o !== 2'b00) begin errors++; $display("FAIL dual_after_commit got %b want 00", commit_o); end
    checks++; if (rdata_o[31:0] !== 32'h11111111) begin errors++; $display("FAIL dual_stored_r3 got %h want 11111111", rdata_o[31:0]); end
    checks++; if (rdata_o[63:32] !== 32'h22222222) begin errors++; $display("FAIL dual_stored_r4 got %h want 22222222", rdata_o[63:32]); end
  endtask

  task automatic test_same_addr();
    in_b = '0;
    in_b.v1 = 1; in_b.we1 = 1; in_b.wa1 = 5'd7; in_b.wd1 = 32'hAAAA0000;
    in_b.v2 = 1; in_b.we2 = 1; in_b.wa2 = 5'd7; in_b.wd2 = 32'h0000BBBB;
    mem_valid_i = 1;
    tick();
    mem_valid_i = 0; in_b = '0;
    set_reads(5'd7, 5'd7, 5'd7, 5'd7);
    #1;
    checks++; if (rdata_o[31:0] !== 32'h0000BBBB) begin errors++; $display("FAIL same_addr_bypass got %h want 0000bbbb", rdata_o[31:0]); end
    tick(); #1;
    checks++; if (rdata_o[127:96] !== 32'h0000BBBB) begin errors++; $display("FAIL same_addr_stored got %h want 0000bbbb", rdata_o[127:96]); end
  endtask

  task automatic test_r0();
    in_b = '0;
    in_b.v1 = 1; in_b.we1 = 1; in_b.wa1 = 5'd0; in_b.wd1 = 32'hFFFFFFFF;
    in_b.v2 = 1; in_b.we2 = 1; in_b.wa2 = 5'd0; in_b.wd2 = 32'hFFFFFFFF;
    mem_valid_i = 1;
    tick();
    mem_valid_i = 0; in_b = '0;
    set_reads(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if (rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h want 0", rdata_o[31:0]); end
    checks++; if (commit_o !== 2'b11) begin errors++; $display("FAIL r0_commit got %b want 11", commit_o); end
    tick(); #1;
    checks++; if (rdata_o[63:32] !== 32'h0) begin errors++; $display("FAIL r0_stored got %h want 0", rdata_o[63:32]); end
  endtask

  task automatic test_stall();
    in_b = '0;
    in_b.v1 = 1; in_b.we1 = 1; in_b.wa1 = 5'd9; in_b.wd1 = 32'h99990001;
    mem_valid_i = 1;
    tick();
    wb_stall_i = 1;
    in_b.wd1 = 32'hDEADBEEF; in_b.v2 = 1; in_b.we2 = 1; in_b.wa2 = 5'd9; in_b.wd2 = 32'hCAFEF00D;
    set_reads(5'd9, 5'd9, 5'd9, 5'd9);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (wb_allowin_o !== 1'b0) begin errors++; $display("FAIL stall_allowin cyc%0d got %b want 0", c, wb_allowin_o); end
      checks++; if (commit_o !== 2'b00) begin errors++; $display("FAIL stall_commit cyc%0d got %b want 00", c, commit_o); end
      checks++; if (rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL stall_nobypass cyc%0d got %h want 0", c, rdata_o[31:0]); end
      checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL stall_wb_valid cyc%0d got %b want 1", c, wb_valid_o); end
      tick();
    end
    wb_stall_i = 0; mem_valid_i = 0; in_b = '0;
    #1;
    checks++; if (commit_o !== 2'b01) begin errors++; $display("FAIL stall_release_commit got %b want 01", commit_o); end
    checks++; if (rdata_o[31:0] !== 32'h99990001) begin errors++; $display("FAIL stall_release_bypass got %h want 99990001", rdata_o[31:0]); end
    tick(); #1;
    checks++; if (rdata_o[31:0] !== 32'h99990001) begin errors++; $display("FAIL stall_stored got %h want 99990001", rdata_o[31:0]); end
    checks++; if (commit_o !== 2'b00) begin errors++; $display("FAIL stall_single_commit got %b want 00", commit_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", wb_valid_o); end
  endtask

  task automatic test_llbit();
    in_b = '0; in_b.v1 = 1; in_b.llwe1 = 1; in_b.lld1 = 1;
    mem_valid_i = 1;
    tick();
    mem_valid_i = 0; in_b = '0;
    #1;
    checks++; if (llbit_rdata_o !== 1'b1) begin errors++; $display("FAIL llbit_set_bypass got %b want 1", llbit_rdata_o); end
    tick(); #1;
    checks++; if (llbit_rdata_o !== 1'b1) begin errors++; $display("FAIL llbit_set_stored got %b want 1", llbit_rdata_o); end
    in_b.v1 = 1; in_b.llwe1 = 1; in_b.lld1 = 1;
    in_b.v2 = 1; in_b.llwe2 = 1; in_b.lld2 = 0;
    mem_valid_i = 1;
    tick();
    mem_valid_i = 0; in_b = '0;
    #1;
    checks++; if (llbit_rdata_o !== 1'b0) begin errors++; $display("FAIL llbit_prio_bypass got %b want 0", llbit_rdata_o); end
    tick(); #1;
    checks++; if (llbit_rdata_o !== 1'b0) begin errors++; $display("FAIL llbit_prio_stored got %b want 0", llbit_rdata_o); end
  endtask

  task automatic test_flush();
    in_b = '0; in_b.v1 = 1; in_b.we1 = 1; in_b.wa1 = 5'd12; in_b.wd1 = 32'h12121212;
    mem_valid_i = 1; flush_i = 1;
    tick();
    mem_valid_i = 0; flush_i = 0; in_b = '0;
    set_reads(5'd12, 5'd12, 5'd12, 5'd12);
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_wb_valid got %b want 0", wb_valid_o); end
    checks++; if (commit_o !== 2'b00) begin errors++; $display("FAIL flush_commit got %b want 00", commit_o); end
    tick(); #1;
    checks++; if (rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL flush_nowrite got %h want 0", rdata_o[31:0]); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      mem_valid_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 7) == 0);
      wb_stall_i  = ($urandom_range(0, 3) == 0);
      in_b.v1 = $urandom_range(0, 1); in_b.we1 = $urandom_range(0, 1);
      in_b.wa1 = 5'($urandom_range(0, 7)); in_b.wd1 = $urandom;
      in_b.llwe1 = $urandom_range(0, 1); in_b.lld1 = $urandom_range(0, 1);
      in_b.v2 = $urandom_range(0, 1); in_b.we2 = $urandom_range(0, 1);
      in_b.wa2 = 5'($urandom_range(0, 7)); in_b.wd2 = $urandom;
      in_b.llwe2 = $urandom_range(0, 1); in_b.lld2 = $urandom_range(0, 1);
      re_i = 4'($urandom_range(0, 15));
      raddr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      checks++; if (wb_allowin_o !== (!m_wbv || !wb_stall_i)) begin errors++; $display("FAIL rnd_allowin cyc%0d got %b", c, wb_allowin_o); end
      checks++; if (wb_valid_o !== m_wbv) begin errors++; $display("FAIL rnd_wb_valid cyc%0d got %b want %b", c, wb_valid_o, m_wbv); end
      checks++; if (commit_o !== exp_commit()) begin errors++; $display("FAIL rnd_commit cyc%0d got %b want %b", c, commit_o, exp_commit()); end
      checks++; if (llbit_rdata_o !== exp_ll()) begin errors++; $display("FAIL rnd_llbit cyc%0d got %b want %b", c, llbit_rdata_o, exp_ll()); end
      for (int p = 0; p < 4; p++) begin
        logic [31:0] want;
        want = exp_read(re_i[p], raddr_i[p*5 +: 5]);
        checks++;
        if (rdata_o[p*32 +: 32] !== want) begin
          errors++;
          $display("FAIL rnd_rdata cyc%0d port%0d got %h want %h", c, p, rdata_o[p*32 +: 32], want);
        end
      end
      tick();
    end
    mem_valid_i = 0; flush_i = 0; wb_stall_i = 0; in_b = '0;
    tick();
  endtask

  task automatic test_reset_midstall();
    in_b = '0; in_b.v1 = 1; in_b.llwe1 = 1; in_b.lld1 = 1;
    mem_valid_i = 1;
    tick();
    in_b = '0; in_b.v1 = 1; in_b.we1 = 1; in_b.wa1 = 5'd3; in_b.wd1 = 32'h33333333;
    tick();
    wb_stall_i = 1; mem_valid_i = 0; in_b = '0;
    set_reads(5'd3, 5'd3, 5'd3, 5'd3);
    #1;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL midstall_wb_valid got %b want 1", wb_valid_o); end
    checks++; if (llbit_rdata_o !== 1'b1) begin errors++; $display("FAIL midstall_llbit got %b want 1", llbit_rdata_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_wb_valid got %b want 0", wb_valid_o); end
    checks++; if (llbit_rdata_o !== 1'b0) begin errors++; $display("FAIL async_rst_llbit got %b want 0", llbit_rdata_o); end
    checks++; if (rdata_o[31:0] !== 32'h0) begin errors++; $display("FAIL async_rst_gpr got %h want 0", rdata_o[31:0]); end
    model_reset();
    wb_stall_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_same_addr();
    test_r0();
    test_stall();
    test_llbit();
    test_flush();
    test_back_to_back();
    test_reset_midstall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_wb_regfile.md
Name: dual_wb_regfile

Overview:
- Writeback stage plus dual-write-port architectural register file and LLbit register for the dual-issue pipeline.
- Latches the two-line payload from MEM and commits both lines' GPR and LLbit writes.
- Serves the four ID read ports and the LLbit read. These are the "old" read values that the ID forwarding logic corrects using EX and MEM results.
- Same-cycle WB writes bypass straight to the read ports, so ID never needs a WB forwarding path.

Parameters:
- NREG, 32, number of GPRs; r0 is hardwired to zero.
- AW, 5, register address width (log2 NREG).
- DW, 32, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous active-low
- mem_valid_i  in  1  MEM holds a valid bundle for WB
- wb_allowin_o  out  1  WB can accept a bundle this cycle
- wb_stall_i  in  1  hold the WB bundle (not committed while high)
- flush_i  in  1  drop the incoming MEM bundle
- l1_valid_i, l2_valid_i  in  1 each  per-line instruction valid inside the bundle
- l1_we_i, l2_we_i  in  1 each  GPR write enable
- l1_waddr_i, l2_waddr_i  in  AW each  GPR write address
- l1_wdata_i, l2_wdata_i  in  DW each  GPR write data
- l1_llbit_we_i, l1_llbit_wdata_i  in  1 each  LLbit write (line1 only)
- l2_llbit_we_i, l2_llbit_wdata_i  in  1 each  LLbit write (line2)
- re_i  in  4  read enables {l2_re2, l2_re1, l1_re2, l1_re1}
- raddr_i  in  4*AW  read addresses, same packing as re_i
- rdata_o  out  4*DW  read data, same packing
- llbit_rdata_o  out  1  current LLbit
- wb_valid_o  out  1  WB holds a bundle
- commit_o  out  2  per-line commit strobe {l2, l1}

Behaviour:
- Reset (rst_n low, asynchronous):
  - wb_valid, all GPRs and LLbit clear to 0.
  - commit_o = 0, wb_allowin_o = 1, all rdata_o = 0.
- Handshake:
  - ready_go = !wb_stall_i.
  - wb_allowin_o = !wb_valid || ready_go.
  - On a rising edge with wb_allowin_o high: wb_valid <= mem_valid_i && !flush_i, and the payload is captured when mem_valid_i is high.
  - While stalled, the payload holds stable.
- Latency: a bundle accepted at edge N commits at edge N+1, provided it is not stalled during cycle N..N+1.
- Commit condition:
  - Line k commits when wb_valid && ready_go && lk_valid.
  - commit_o[k] reflects that condition combinationally during the cycle.
- GPR write:
  - Line k writes reg[waddr] <= wdata on the edge when it commits, lk_we = 1 and waddr != 0.
  - If both lines write the same address, line2 (younger) wins.
- LLbit write:
  - Line2 has priority over line1 when both lines write LLbit in the same commit.
  - LLbit is never cleared except by reset or an explicit write.
- Read path (combinational):
  - If re = 0 or raddr = 0, the port returns 0.
  - Otherwise, if line2 is committing a GPR write to that address this cycle, return l2 wdata.
  - Else if line1 is, return l1 wdata.
  - Else return the stored value.
- LLbit read: llbit_rdata_o applies the same bypass to LLbit (line2 over line1 over stored).
- Stalled cycle: no commit, no bypass, no state change.
- flush_i only gates capture; a bundle already in WB commits normally.
- Simultaneous accept and commit: the old bundle commits and the new one is captured on the same edge.

Test Plan:
- Reset, then read r5 and r0 with re=1 -> both 0; llbit_rdata_o=0; wb_allowin_o=1.
- Bundle with l1 writing r3=0x11111111, l2 writing r4=0x22222222; read r3/r4 one cycle later -> 0x11111111/0x22222222 on commit cycle (bypass) and afterwards (stored); commit_o=2'b11.
- Both lines write r7 (l1=0xAAAA0000, l2=0x0000BBBB) -> stored r7 = 0x0000BBBB and bypass returns 0x0000BBBB.
- Write to r0 with 0xFFFFFFFF -> r0 reads 0.
- Hold wb_stall_i=1 for 3 cycles -> wb_allowin_o=0, commit_o=0, no write; MEM payload changes ignored; release -> single commit of the original data.
- l1 LLbit we=1 data=1 and l2 LLbit we=1 data=0 -> LLbit=0.
- flush_i with mem_valid_i=1 -> wb_valid_o=0 next cycle and no write.
- Assert rst_n low mid-stall -> wb_valid_o and LLbit drop immediately.
